sram_like_responder: RTL
========================

Name: sram_like_responder

Overview:
- Target (slave) side of the SRAM-like req/addr_ok/data_ok bus that the CPU wrapper drives for both its instruction and data ports.
- Backs the bus with a word-organised internal memory and returns responses in order.
- Has configurable address-accept and response delays so the CPU-side handshake and stall logic can be stressed in simulation and on-board bring-up.
- Keeps a bounded outstanding-request queue and a sticky protocol-error flag.

Parameters:
- ADDR_W, 12: word-index bits; memory holds 2^ADDR_W 32-bit words, indexed by addr[ADDR_W+1:2].
- OUTSTANDING, 2: maximum accepted-but-unanswered requests (queue depth, ≥1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- req  in  1  request valid, held by initiator until addr_ok
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word
- wstrb  in  4  write byte enables
- addr  in  32  byte address
- wdata  in  32  write data
- addr_ok  out  1  request accepted this cycle (combinational)
- data_ok  out  1  response valid this cycle
- rdata  out  32  read data, valid with data_ok
- cfg_addr_delay  in  4  cycles req must be held before addr_ok may assert
- cfg_data_delay  in  4  extra response cycles, sampled per request at accept
- err  out  1  sticky protocol error

Behaviour:
- Reset (async): addr_ok=0, data_ok=0, rdata=0, err=0, queue empty, hold counter 0. Memory contents are not reset. Reset mid-transaction drops all queued responses; data_ok deasserts immediately.
- Hold counter:
  - Increments (saturating at 15) each cycle req=1 without accept.
  - Clears on accept or when req=0.
- addr_ok = req && hold_cnt >= cfg_addr_delay && count < OUTSTANDING. Full blocks acceptance even if a pop occurs the same cycle.
- Accept = req && addr_ok at posedge.
- On an accepted write:
  - Byte lanes with wstrb[i]=1 update mem[addr[ADDR_W+1:2]][8i+7:8i]; other lanes are unchanged.
  - Enqueue an entry {rdata=0, delay=cfg_data_delay}.
- On an accepted read: enqueue {rdata=mem word read combinationally at the accept edge, delay=cfg_data_delay}. A read after a write to the same word sees the new data, because both take effect at their accept edges.
- Address bits above ADDR_W+1 are ignored; addresses alias (wrap).
- Head counter:
  - Loads the entry's delay when the entry becomes head (enqueue into empty queue, or pop with a successor present).
  - Decrements each cycle while >0.
- data_ok = !empty && head_cnt==0. rdata = head rdata when data_ok=1, else 0.
- The initiator never back-pressures data; the head pops on every cycle data_ok=1.
- Latency: with cfg_data_delay=d and an empty queue, data_ok asserts d+1 cycles after the accept edge. Back-to-back responses are possible on consecutive cycles when d=0.
- Simultaneous enqueue and pop: count is unchanged. An enqueue into a queue whose only entry pops the same cycle becomes head and loads its delay.
- err is set (sticky until reset) on an accepted request when any of these hold:
  - size=3
  - size=1 with addr[0]=1
  - size=2 with addr[1:0]≠0
  - a write whose wstrb is not exactly the lanes implied by size and addr[1:0] (byte: one bit at addr[1:0]; half: 0011 or 1100; word: 1111)
  - a read with wstrb≠0
  
  The request is still executed and answered normally.

Test Plan:
- Write then read, delays 0:
  - Stimulus: write addr=0x1C0, wdata=0xDEADBEEF, wstrb=1111; then read addr=0x1C0.
  - Required: addr_ok same cycle as req; data_ok one cycle after each accept; read rdata=0xDEADBEEF; err=0.
- Byte write:
  - Stimulus: preload word 0x11223344; write size=0, addr=0x1C2, wstrb=0100, wdata=0x00AA0000; read back.
  - Required: rdata=0x11AA3344.
- Address delay:
  - Stimulus: cfg_addr_delay=3; hold req.
  - Required: addr_ok first high on the 4th req cycle; drop req after 2 cycles, reassert, counter restarts.
- Queue full:
  - Stimulus: OUTSTANDING=2, cfg_data_delay=5; issue 3 consecutive reads.
  - Required: first two accepted on consecutive cycles; third addr_ok stays low until the cycle after the first data_ok pop; responses arrive in order.
- Error flag:
  - Stimulus: write size=2, addr=0x102.
  - Required: err=1 and held; memory still written and data_ok returned; subsequent legal traffic leaves err=1 until resetn pulse.
- Reset mid-operation:
  - Stimulus: accept a read with cfg_data_delay=4; assert resetn=0 two cycles later.
  - Required: data_ok never asserts for that read; after reset release addr_ok=0 until the next req.

Source files
------------

// File: rtl/sram_like_responder.sv
// Target side of the SRAM-like req/addr_ok/data_ok bus: word-organised memory,
// in-order response queue with programmable accept and response delays.
module sram_like_responder #(
  parameter int ADDR_W      = 12,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic [3:0]  cfg_addr_delay,
  input  logic [3:0]  cfg_data_delay,
  output logic        err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int DEPTH = 1 << ADDR_W;

  // Handshake: a request transfers on a posedge where req && addr_ok; the
  // initiator holds all request fields stable until then. Responses are never
  // back-pressured: every cycle with data_ok high retires the queue head.

  logic [31:0]       mem [0:DEPTH-1];
  logic [31:0]       q_data  [0:OUTSTANDING-1];
  logic [3:0]        q_delay [0:OUTSTANDING-1];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [3:0]        hold_cnt;
  logic [3:0]        head_cnt;
  logic              empty;
  logic              full;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       mem_word;
  logic [3:0]        lane_mask;
  logic              proto_bad;
  logic              unused_addr_bits;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign word_idx         = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^addr[31:ADDR_W+2];
  assign mem_word         = mem[word_idx];
  assign empty            = (count == '0);
  assign full             = (count == CNT_W'(OUTSTANDING));
  // A pop in the same cycle does not free a slot for acceptance.
  assign addr_ok          = req && (hold_cnt >= cfg_addr_delay) && !full;
  assign accept           = req && addr_ok;
  assign data_ok          = !empty && (head_cnt == 4'd0);
  assign pop              = data_ok;
  assign rdata            = data_ok ? q_data[rd_ptr] : 32'd0;

  always_comb begin
    lane_mask = 4'b0000;
    case (size)
      2'd0:    lane_mask = 4'b0001 << addr[1:0];
      2'd1:    lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
    proto_bad = (size == 2'd3)
             || (size == 2'd1 && addr[0])
             || (size == 2'd2 && addr[1:0] != 2'b00)
             || (wr  && wstrb != lane_mask)
             || (!wr && wstrb != 4'b0000);
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      q_data[wr_ptr]  <= wr ? 32'd0 : mem_word;
      q_delay[wr_ptr] <= cfg_data_delay;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt <= 4'd0;
      head_cnt <= 4'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      if (!req || accept)        hold_cnt <= 4'd0;
      else if (hold_cnt != 4'hF) hold_cnt <= hold_cnt + 4'd1;

      if (accept) wr_ptr <= next_ptr(wr_ptr);
      if (pop)    rd_ptr <= next_ptr(rd_ptr);

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // The head counter reloads whenever a new entry becomes head.
      if (pop) begin
        if (count > CNT_W'(1))  head_cnt <= q_delay[next_ptr(rd_ptr)];
        else if (accept)        head_cnt <= cfg_data_delay;
      end else if (accept && empty) begin
        head_cnt <= cfg_data_delay;
      end else if (head_cnt != 4'd0) begin
        head_cnt <= head_cnt - 4'd1;
      end

      if (accept && proto_bad) err <= 1'b1;
    end
  end

endmodule
